// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_control_unit_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  // Architectural zero register: never a real dependency.
  localparam logic [4:0] REG_X0 = 5'd0;

  // Per-stage control bundle driven to the pipeline registers.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_freeze;
  } ctrl_t;

  // Free-running pipeline: fetch and decode advance, nothing squashed.
  localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, if_id_write: 1'b1, default: 1'b0};

  // Whole pipeline held while data memory is busy.
  localparam ctrl_t CTRL_FREEZE = '{pipe_freeze: 1'b1, default: 1'b0};

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count enabled cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard sequencing for the 5-stage core: load-use stalls, taken-branch
// flushes and data-memory wait freezes, plus statistics and a timeout flag.
// Control outputs are Mealy (state + current inputs); while rst is high they
// are forced to the idle RUN values so reset is visible immediately.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_RegisterRD,
  input  logic [4:0]       IF_ID_RegisterRS1,
  input  logic [4:0]       IF_ID_RegisterRS2,
  input  logic             Branch_Taken,
  input  logic             EX_MEM_MemAccess,
  input  logic             DMem_Ready,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             Pipe_Freeze,
  output logic             Mem_Error,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count,
  output logic [CNT_W-1:0] Wait_Count
);

  localparam int FW = 3;                       // flush counter holds 0..4
  localparam int TW = $clog2(MEM_TIMEOUT + 1); // consecutive-wait run length

  state_e        state, ret_state;
  logic [FW-1:0] flush_cnt, ret_flush_cnt;
  logic [TW-1:0] wait_run;
  ctrl_t         ctrl;
  logic          load_use, mem_stall, stall_inc;

  assign load_use  = ID_EX_MemRead && (ID_EX_RegisterRD != REG_X0) &&
                     ((ID_EX_RegisterRD == IF_ID_RegisterRS1) ||
                      (ID_EX_RegisterRD == IF_ID_RegisterRS2));
  assign mem_stall = EX_MEM_MemAccess && !DMem_Ready;

  // Select this cycle's pipeline controls; memory wait beats branch beats load-use.
  always_comb begin
    ctrl      = CTRL_RUN;
    stall_inc = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            ctrl = CTRL_FREEZE;
          end else if (Branch_Taken) begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
          end else if (load_use) begin
            ctrl.pc_write     = 1'b0;
            ctrl.if_id_write  = 1'b0;
            ctrl.id_ex_bubble = 1'b1;
            stall_inc         = 1'b1;
          end
        end
        FLUSH: begin
          // ID holds a squashed slot, so load-use is irrelevant here.
          if (mem_stall) begin
            ctrl = CTRL_FREEZE;
          end else begin
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_bubble = Branch_Taken;
          end
        end
        MEM_WAIT: begin
          // EX is held, so branch and load-use are not acted on until release.
          if (!DMem_Ready) ctrl = CTRL_FREEZE;
        end
        default: ctrl = CTRL_RUN;
      endcase
    end
  end

  assign PCWrite      = ctrl.pc_write;
  assign IF_ID_Write  = ctrl.if_id_write;
  assign IF_ID_Flush  = ctrl.if_id_flush;
  assign ID_EX_Bubble = ctrl.id_ex_bubble;
  assign Pipe_Freeze  = ctrl.pipe_freeze;

  // Sequence RUN/FLUSH/MEM_WAIT and track the memory-wait run for the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      ret_state     <= RUN;
      flush_cnt     <= '0;
      ret_flush_cnt <= '0;
      wait_run      <= '0;
      Mem_Error     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state         <= MEM_WAIT;
            ret_state     <= RUN;
            ret_flush_cnt <= flush_cnt;
          end else if (Branch_Taken && (FLUSH_CYCLES > 1)) begin
            state     <= FLUSH;
            flush_cnt <= FW'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          if (mem_stall) begin
            state         <= MEM_WAIT;
            ret_state     <= FLUSH;
            ret_flush_cnt <= flush_cnt;
          end else if (Branch_Taken) begin
            if (FLUSH_CYCLES > 1) flush_cnt <= FW'(FLUSH_CYCLES - 1);
            else                  state     <= RUN;
          end else if (flush_cnt <= FW'(1)) begin
            state <= RUN;
          end else begin
            flush_cnt <= flush_cnt - FW'(1);
          end
        end
        MEM_WAIT: begin
          if (DMem_Ready) begin
            state     <= ret_state;
            flush_cnt <= ret_flush_cnt;
          end
        end
        default: state <= RUN;
      endcase

      if (ctrl.pipe_freeze) begin
        if (wait_run != TW'(MEM_TIMEOUT)) wait_run <= wait_run + TW'(1);
        if (wait_run == TW'(MEM_TIMEOUT - 1)) Mem_Error <= 1'b1;
      end else begin
        wait_run <= '0;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .en(stall_inc), .clr(1'b0), .count(Stall_Count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .en(ctrl.if_id_flush), .clr(1'b0), .count(Flush_Count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk(clk), .rst(rst), .en(ctrl.pipe_freeze), .clr(1'b0), .count(Wait_Count)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with hand-computed expectations.
// Control vector order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Pipe_Freeze}.
module tb_hazard_control_unit;

  localparam int MEM_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic [4:0]  rd, rs1, rs2;
  logic        branch, mem_access, dmem_ready;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, mem_error;
  logic [15:0] stall_count, flush_count, wait_count;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [4:0] C_RUN    = 5'b11000;
  localparam logic [4:0] C_STALL  = 5'b00010;
  localparam logic [4:0] C_BRANCH = 5'b11110;
  localparam logic [4:0] C_FLUSH  = 5'b11100;
  localparam logic [4:0] C_FREEZE = 5'b00001;

  hazard_control_unit #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ID_EX_MemRead(mem_read), .ID_EX_RegisterRD(rd),
    .IF_ID_RegisterRS1(rs1), .IF_ID_RegisterRS2(rs2),
    .Branch_Taken(branch), .EX_MEM_MemAccess(mem_access), .DMem_Ready(dmem_ready),
    .PCWrite(pc_write), .IF_ID_Write(if_id_write), .IF_ID_Flush(if_id_flush),
    .ID_EX_Bubble(id_ex_bubble), .Pipe_Freeze(pipe_freeze), .Mem_Error(mem_error),
    .Stall_Count(stall_count), .Flush_Count(flush_count), .Wait_Count(wait_count)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic br, input logic acc, input logic rdy);
    mem_read = mr; rd = d; rs1 = s1; rs2 = s2;
    branch = br; mem_access = acc; dmem_ready = rdy;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Check combinational controls mid-cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [4:0] exp);
    #1;
    check_val(tag, {27'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze},
              {27'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag, input int s, input int f, input int w);
    check_val({tag, "_stall"}, {16'd0, stall_count}, s);
    check_val({tag, "_flush"}, {16'd0, flush_count}, f);
    check_val({tag, "_wait"},  {16'd0, wait_count},  w);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    check_val("reset_ctrl", {27'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze},
              {27'd0, C_RUN});
    check_val("reset_err", {31'd0, mem_error}, 32'd0);
    check_counts("reset", 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Load-use on rs1, then rs2.
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1); cyc("lu_rs1", C_STALL);
    idle();                                          cyc("lu_after", C_RUN);
    drive(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b1); cyc("lu_rs2", C_STALL);
    check_counts("lu", 2, 0, 0);
    // No stall when rd is x0 or there is no match.
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); cyc("lu_x0", C_RUN);
    drive(1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0, 1'b1); cyc("lu_nomatch", C_RUN);
    drive(1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1); cyc("lu_noload", C_RUN);
    check_counts("lu_none", 2, 0, 0);

    // Taken branch: two flush cycles then back to RUN.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1); cyc("br_cycle1", C_BRANCH);
    idle();                                          cyc("br_cycle2", C_FLUSH);
    idle();                                          cyc("br_done", C_RUN);
    check_counts("br", 2, 2, 0);

    // Branch with simultaneous load-use: flush only; load-use ignored in FLUSH.
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1); cyc("br_lu1", C_BRANCH);
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1); cyc("br_lu2", C_FLUSH);
    idle();                                          cyc("br_lu_done", C_RUN);
    check_counts("br_lu", 2, 4, 0);

    // Memory wait for 3 cycles; branch during freeze is ignored.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); cyc("mw_1", C_FREEZE);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0); cyc("mw_2_br", C_FREEZE);
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0); cyc("mw_3_lu", C_FREEZE);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1); cyc("mw_release", C_RUN);
    idle();                                          cyc("mw_after", C_RUN);
    check_counts("mw", 2, 4, 3);

    // Freeze in the second flush cycle; remaining flush cycle resumes after.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1); cyc("fz_br", C_BRANCH);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); cyc("fz_freeze", C_FREEZE);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1); cyc("fz_release", C_RUN);
    idle();                                          cyc("fz_resume", C_FLUSH);
    idle();                                          cyc("fz_done", C_RUN);
    check_counts("fz", 2, 6, 4);

    // Timeout: error appears only after MEM_TIMEOUT frozen cycles.
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); cyc("to_freeze", C_FREEZE);
    end
    check_val("to_err_early", {31'd0, mem_error}, 32'd0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); cyc("to_last", C_FREEZE);
    check_val("to_err_set", {31'd0, mem_error}, 32'd1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1); cyc("to_release", C_RUN);
    idle();                                          cyc("to_after", C_RUN);
    check_val("to_err_sticky", {31'd0, mem_error}, 32'd1);
    check_counts("to", 2, 6, 4 + MEM_TIMEOUT);

    // Reset asserted mid-MEM_WAIT with memory still busy.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); cyc("rs_freeze1", C_FREEZE);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); cyc("rs_freeze2", C_FREEZE);
    rst = 1'b1;
    #1;
    check_val("rs_async_ctrl", {27'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze},
              {27'd0, C_RUN});
    check_val("rs_async_err", {31'd0, mem_error}, 32'd0);
    check_counts("rs_async", 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();                                          cyc("rs_run", C_RUN);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1); cyc("rs_br", C_BRANCH);
    idle();                                          cyc("rs_flush", C_FLUSH);
    idle();                                          cyc("rs_done", C_RUN);
    check_counts("rs", 0, 2, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline sequencing controller for the 5-stage RISC-V core. It sits beside the forwarding logic in the decode/execute boundary and resolves the hazards forwarding cannot cover: load-use stalls, taken-branch flushes and data-memory wait freezes. It drives the per-stage write-enable/flush controls and keeps hazard statistics plus a sticky memory-timeout flag.

## Interface
- Clocking: one clock; reset is asynchronous and active-high.
- Parameters:
- FLUSH_CYCLES, 2, cycles of IF/ID flush after a taken branch (1..4)
- MEM_TIMEOUT, 64, max consecutive data-memory wait cycles before Mem_Error
- CNT_W, 16, width of statistics counters
- Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous active-high reset
- ID_EX_MemRead  input  1  instruction in EX is a load
- ID_EX_RegisterRD  input  5  destination of instruction in EX
- IF_ID_RegisterRS1  input  5  source 1 of instruction in ID
- IF_ID_RegisterRS2  input  5  source 2 of instruction in ID
- Branch_Taken  input  1  branch/jump in EX resolved taken (1-cycle pulse)
- EX_MEM_MemAccess  input  1  instruction in MEM accesses data memory
- DMem_Ready  input  1  data memory completes access this cycle
- PCWrite  output  1  PC update enable
- IF_ID_Write  output  1  IF/ID register enable
- IF_ID_Flush  output  1  clear IF/ID to NOP
- ID_EX_Bubble  output  1  load zero controls into ID/EX
- Pipe_Freeze  output  1  hold ID/EX, EX/MEM, MEM/WB
- Mem_Error  output  1  sticky memory timeout flag
- Stall_Count  output  CNT_W  load-use stall cycles
- Flush_Count  output  CNT_W  flush cycles
- Wait_Count  output  CNT_W  memory wait cycles

## Operation
- States: RUN, FLUSH, MEM_WAIT. Reset -> RUN.
- Defaults (RUN, no hazard): PCWrite=1, IF_ID_Write=1, others 0.
- Load-use (RUN): ID_EX_MemRead && RD!=0 && (RD==RS1 || RD==RS2) -> PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 same cycle; stay RUN; Stall_Count+1.
- Taken branch (RUN): IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1 same cycle; Flush_Count+1; if FLUSH_CYCLES>1 go FLUSH with counter=FLUSH_CYCLES-1.
- FLUSH: IF_ID_Flush=1, PCWrite=1, Flush_Count+1 per cycle; decrement; at counter==1 -> RUN. Load-use ignored in FLUSH (ID content is squashed). New Branch_Taken in FLUSH reloads counter to FLUSH_CYCLES-1.
- Memory wait (any state): EX_MEM_MemAccess && !DMem_Ready -> Pipe_Freeze=1, PCWrite=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Bubble=0; enter MEM_WAIT, saving return state and flush counter; Wait_Count+1.
- MEM_WAIT: freeze held while !DMem_Ready; wait counter increments; on DMem_Ready freeze drops that cycle, return to saved state next cycle. Branch_Taken and load-use ignored while frozen (EX held).
- Priority: memory wait > branch > load-use.
- Timeout: wait counter reaching MEM_TIMEOUT sets Mem_Error (sticky until rst); freeze continues.
- Counters saturate at all-ones; no wrap.

## Timing
- Control outputs combinational from state + inputs (Mealy), zero latency; state, counters, Mem_Error registered.
- Reset values: state RUN, all counters 0, Mem_Error 0; outputs then PCWrite=1, IF_ID_Write=1, rest 0 (given idle inputs).
- rst asserted mid-FLUSH/MEM_WAIT: immediate return to RUN, counters and saved state cleared.
- Branch and load-use same cycle: flush only, Stall_Count unchanged.

## Structure
- Shared package: state enum (RUN/FLUSH/MEM_WAIT), x0 register constant, control-bundle typedef.
- One sub-module: sat_counter (CNT_W, enable, sync clear, async reset) instanced three times.

## Test plan
- Load x5 in EX, ID uses rs1=x5 -> one cycle PCWrite=0, ID_EX_Bubble=1, Stall_Count=1; rd=x0 -> no stall.
- Branch_Taken pulse, FLUSH_CYCLES=2 -> IF_ID_Flush high 2 cycles, Flush_Count=2, back to RUN.
- MemAccess with DMem_Ready low 3 cycles -> Pipe_Freeze high 3 cycles, Wait_Count=3, release on ready cycle.
- Freeze during FLUSH cycle 2 -> after ready, remaining flush cycle resumes; total Flush_Count=2.
- DMem_Ready low MEM_TIMEOUT cycles -> Mem_Error=1, stays 1 after ready until rst.
- rst pulse mid-MEM_WAIT -> outputs at reset values asynchronously, counters 0.
